// File: rtl/neuron_accumulator.sv
// Per-neuron signed membrane potentials fed by routed synapse events; on each tick
// every neuron is scanned in ID order and either leaks toward zero or fires a spike.
module neuron_accumulator #(
    parameter int ID_Width     = 4,
    parameter int Weight_Width = 4,
    parameter int Pot_Width    = 8,
    parameter int Threshold    = 16,
    parameter int Leak         = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    Syn_Valid_In,
    input  logic [ID_Width-1:0]     DstID_In,
    input  logic [Weight_Width-1:0] Weight_In,
    input  logic                    Tick_In,
    output logic                    Spike_Valid_Out,
    output logic [ID_Width-1:0]     Spike_ID_Out,
    input  logic                    Spike_Ready_In,
    output logic                    Busy_Out,
    output logic                    Syn_Drop_Out,
    output logic                    Tick_Miss_Out,
    input  logic [ID_Width-1:0]     Pot_Addr_In,
    output logic [Pot_Width-1:0]    Pot_Out
);

    localparam int unsigned NEURONS = 2 ** ID_Width;
    localparam logic signed [Pot_Width-1:0] THR     = Pot_Width'(Threshold);
    localparam logic signed [Pot_Width-1:0] LEAK_P  = Pot_Width'(Leak);
    localparam logic signed [Pot_Width-1:0] LEAK_N  = Pot_Width'(-Leak);
    localparam logic signed [Pot_Width-1:0] POT_MAX = {1'b0, {(Pot_Width-1){1'b1}}};
    localparam logic signed [Pot_Width-1:0] POT_MIN = {1'b1, {(Pot_Width-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        EMIT
    } state_t;

    state_t state, state_next;

    logic [ID_Width-1:0]         idx;
    logic signed [Pot_Width-1:0] pot [NEURONS];
    logic signed [Pot_Width-1:0] cur_pot, acc_src, acc_pot, leak_pot;
    logic signed [Pot_Width:0]   sum;
    logic                        fire, last;

    assign Pot_Out = pot[Pot_Addr_In];
    assign cur_pot = pot[idx];
    assign fire    = (cur_pot >= THR);
    assign last    = &idx;

    // One guard bit catches overflow: top two bits disagree -> clamp by sign.
    always_comb begin
        acc_src = pot[DstID_In];
        sum     = {acc_src[Pot_Width-1], acc_src}
                + {{(Pot_Width+1-Weight_Width){Weight_In[Weight_Width-1]}}, Weight_In};
        if (sum[Pot_Width] != sum[Pot_Width-1]) begin
            acc_pot = sum[Pot_Width] ? POT_MIN : POT_MAX;
        end else begin
            acc_pot = sum[Pot_Width-1:0];
        end
    end

    always_comb begin
        if (cur_pot > LEAK_P) begin
            leak_pot = cur_pot - LEAK_P;
        end else if (cur_pot < LEAK_N) begin
            leak_pot = cur_pot + LEAK_P;
        end else begin
            leak_pot = '0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (Tick_In) state_next = SCAN;
            SCAN: begin
                if (fire) begin
                    state_next = EMIT;
                end else if (last) begin
                    state_next = IDLE;
                end
            end
            EMIT: if (Spike_Ready_In) state_next = last ? IDLE : SCAN;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx             <= '0;
            Spike_Valid_Out <= 1'b0;
            Spike_ID_Out    <= '0;
            Busy_Out        <= 1'b0;
            Syn_Drop_Out    <= 1'b0;
            Tick_Miss_Out   <= 1'b0;
        end else begin
            Busy_Out      <= (state_next != IDLE);
            Syn_Drop_Out  <= Syn_Valid_In && (state != IDLE);
            Tick_Miss_Out <= Tick_In && (state != IDLE);
            case (state)
                IDLE: if (Tick_In) idx <= '0;
                SCAN: begin
                    if (fire) begin
                        Spike_Valid_Out <= 1'b1;
                        Spike_ID_Out    <= idx;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                EMIT: begin
                    if (Spike_Ready_In) begin
                        Spike_Valid_Out <= 1'b0;
                        idx             <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NEURONS; i++) begin
                pot[i] <= '0;
            end
        end else if (state == IDLE) begin
            if (Syn_Valid_In) pot[DstID_In] <= acc_pot;
        end else if (state == SCAN) begin
            pot[idx] <= fire ? '0 : leak_pot;
        end
    end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed bench for neuron_accumulator: accumulate, saturate, leak, fire,
// back-pressure, busy-time drops and asynchronous reset mid-emit.
module tb_neuron_accumulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       Syn_Valid_In;
    logic [3:0] DstID_In;
    logic [3:0] Weight_In;
    logic       Tick_In;
    logic       Spike_Valid_Out;
    logic [3:0] Spike_ID_Out;
    logic       Spike_Ready_In;
    logic       Busy_Out;
    logic       Syn_Drop_Out;
    logic       Tick_Miss_Out;
    logic [3:0] Pot_Addr_In;
    logic [7:0] Pot_Out;

    int total = 0;
    int bad   = 0;

    int         cyc;
    int         nspk;
    logic [3:0] first_id;

    always #5 clk = ~clk;

    neuron_accumulator #(
        .ID_Width    (4),
        .Weight_Width(4),
        .Pot_Width   (8),
        .Threshold   (16),
        .Leak        (1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .Syn_Valid_In   (Syn_Valid_In),
        .DstID_In       (DstID_In),
        .Weight_In      (Weight_In),
        .Tick_In        (Tick_In),
        .Spike_Valid_Out(Spike_Valid_Out),
        .Spike_ID_Out   (Spike_ID_Out),
        .Spike_Ready_In (Spike_Ready_In),
        .Busy_Out       (Busy_Out),
        .Syn_Drop_Out   (Syn_Drop_Out),
        .Tick_Miss_Out  (Tick_Miss_Out),
        .Pot_Addr_In    (Pot_Addr_In),
        .Pot_Out        (Pot_Out)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] id, input logic [3:0] w, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            Syn_Valid_In = 1'b1;
            DstID_In     = id;
            Weight_In    = w;
        end
        @(negedge clk);
        Syn_Valid_In = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        Tick_In = 1'b1;
        @(negedge clk);
        Tick_In = 1'b0;
    endtask

    task automatic rdpot(input string tag, input logic [3:0] id, input logic [7:0] exp);
        Pot_Addr_In = id;
        #1;
        chk(tag, Pot_Out, exp);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!Spike_Valid_Out && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, Spike_Valid_Out, 1);
    endtask

    // Called on the negedge right after the tick edge; counts busy negedges and handshakes.
    task automatic scan_watch(output int cycles, output int spikes, output logic [3:0] id0);
        cycles = 0;
        spikes = 0;
        id0    = '0;
        while (Busy_Out && cycles < 200) begin
            if (Spike_Valid_Out && Spike_Ready_In) begin
                if (spikes == 0) id0 = Spike_ID_Out;
                spikes++;
            end
            cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        Syn_Valid_In   = 1'b0;
        DstID_In       = '0;
        Weight_In      = '0;
        Tick_In        = 1'b0;
        Spike_Ready_In = 1'b0;
        Pot_Addr_In    = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // reset state
        chk("rst_valid", Spike_Valid_Out, 0);
        chk("rst_id", Spike_ID_Out, 0);
        chk("rst_busy", Busy_Out, 0);
        chk("rst_drop", Syn_Drop_Out, 0);
        chk("rst_miss", Tick_Miss_Out, 0);
        for (int i = 0; i < 16; i++) rdpot("rst_pot", 4'(i), 8'h00);

        // single spike, busy length
        send(4'd3, 4'd5, 4);
        send(4'd7, 4'd1, 3);
        rdpot("acc_pot3", 4'd3, 8'd20);
        rdpot("acc_pot7", 4'd7, 8'd3);
        Spike_Ready_In = 1'b1;
        tick();
        scan_watch(cyc, nspk, first_id);
        chk("t2_busy_cycles", 16'(cyc), 16'd17);
        chk("t2_nspk", 16'(nspk), 16'd1);
        chk("t2_id", first_id, 4'd3);
        rdpot("t2_pot3", 4'd3, 8'd0);
        rdpot("t2_pot7", 4'd7, 8'd2);

        // negative saturation then leak toward zero
        send(4'd1, 4'b1000, 20);
        rdpot("sat_pot1", 4'd1, 8'h80);
        tick();
        scan_watch(cyc, nspk, first_id);
        chk("t3_busy_cycles", 16'(cyc), 16'd16);
        chk("t3_nspk", 16'(nspk), 16'd0);
        rdpot("t3_pot1", 4'd1, 8'h81);
        rdpot("t3_pot7", 4'd7, 8'd1);

        // back-pressure holds the first spike
        send(4'd2, 4'd5, 4);
        send(4'd5, 4'd7, 4);
        send(4'd5, 4'd2, 1);
        rdpot("t4_pre_pot5", 4'd5, 8'd30);
        Spike_Ready_In = 1'b0;
        tick();
        wait_valid("t4_first_valid");
        chk("t4_id2", Spike_ID_Out, 4'd2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_hold_valid", Spike_Valid_Out, 1);
            chk("t4_hold_id", Spike_ID_Out, 4'd2);
        end
        Spike_Ready_In = 1'b1;
        @(negedge clk);
        chk("t4_after_hs", Spike_Valid_Out, 0);
        wait_valid("t4_second_valid");
        chk("t4_id5", Spike_ID_Out, 4'd5);
        scan_watch(cyc, nspk, first_id);
        chk("t4_idle", Busy_Out, 0);
        chk("t4_tail_nspk", 16'(nspk), 16'd1);
        rdpot("t4_pot2", 4'd2, 8'd0);
        rdpot("t4_pot5", 4'd5, 8'd0);
        rdpot("t4_pot1", 4'd1, 8'h82);
        rdpot("t4_pot7", 4'd7, 8'd0);

        // same-cycle synapse + tick, then drops while busy
        send(4'd4, 4'd5, 3);
        rdpot("t5_pre_pot4", 4'd4, 8'd15);
        @(negedge clk);
        Syn_Valid_In = 1'b1;
        DstID_In     = 4'd4;
        Weight_In    = 4'd1;
        Tick_In      = 1'b1;
        @(negedge clk);
        Tick_In      = 1'b0;
        DstID_In     = 4'd6;
        Weight_In    = 4'd3;
        chk("t5_busy", Busy_Out, 1);
        @(negedge clk);
        Syn_Valid_In = 1'b0;
        chk("t5_drop_pulse", Syn_Drop_Out, 1);
        Tick_In = 1'b1;
        @(negedge clk);
        Tick_In = 1'b0;
        chk("t5_drop_end", Syn_Drop_Out, 0);
        chk("t5_miss_pulse", Tick_Miss_Out, 1);
        @(negedge clk);
        chk("t5_miss_end", Tick_Miss_Out, 0);
        wait_valid("t5_valid");
        chk("t5_id4", Spike_ID_Out, 4'd4);
        scan_watch(cyc, nspk, first_id);
        chk("t5_idle", Busy_Out, 0);
        rdpot("t5_pot6", 4'd6, 8'd0);
        rdpot("t5_pot4", 4'd4, 8'd0);

        // asynchronous reset while a spike is pending
        send(4'd9, 4'd5, 4);
        send(4'd11, 4'd3, 1);
        Spike_Ready_In = 1'b0;
        tick();
        wait_valid("t6_valid");
        chk("t6_id9", Spike_ID_Out, 4'd9);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", Spike_Valid_Out, 0);
        chk("t6_rst_busy", Busy_Out, 0);
        for (int i = 0; i < 16; i++) rdpot("t6_rst_pot", 4'(i), 8'h00);
        @(negedge clk);
        rst_n          = 1'b1;
        Spike_Ready_In = 1'b1;
        tick();
        scan_watch(cyc, nspk, first_id);
        chk("t6_busy_cycles", 16'(cyc), 16'd16);
        chk("t6_nspk", 16'(nspk), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
